// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 5-9 data bits LSB first, optional parity, 1 or 2 stop bits,
// mid-bit sampling on an external oversample tick with start-bit glitch rejection.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 rx,
  input  logic                 s_tick,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_MID       = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_END       = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_DATA_LAST = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] N_STOP_LAST = NW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t                 state;
  logic [SW-1:0]          s;
  logic [NW-1:0]          n;
  logic [DATA_BITS-1:0]   shreg;
  logic                   p_bad;
  logic                   f_bad;
  logic                   rx_p0;
  logic                   rx_s;

  // 1 when data plus received parity bit disagree with the configured parity sense
  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data, input logic pbit);
    return (^{data, pbit}) ^ 1'(PARITY_ODD);
  endfunction

  // Stage p0/s: two-flop synchroniser, idles high
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == DATA && s_tick && s == S_END)
      shreg <= {rx_s, shreg[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      s          <= '0;
      n          <= '0;
      p_bad      <= 1'b0;
      f_bad      <= 1'b0;
      dout       <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
            p_bad <= 1'b0;
            f_bad <= 1'b0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_MID) begin
              if (rx_s) begin
                state <= IDLE;
              end else begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_END) begin
              s <= '0;
              if (n == N_DATA_LAST) begin
                n     <= '0;
                state <= (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (s == S_END) begin
              p_bad <= parity_mismatch(shreg, rx_s);
              state <= STOP;
              s     <= '0;
              n     <= '0;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == S_END) begin
              s <= '0;
              if (n != N_STOP_LAST) begin
                n     <= n + 1'b1;
                f_bad <= f_bad | ~rx_s;
              end else begin
                n          <= '0;
                f_bad      <= f_bad | ~rx_s;
                dout       <= shreg;
                parity_err <= p_bad;
                frame_err  <= f_bad | ~rx_s;
                rx_done    <= 1'b1;
                state      <= rx_s ? IDLE : BRK;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        BRK: begin
          // a line held low must rise before another start edge is trusted
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four configurations driven from a tick-counted serial driver,
// directed frames plus random frames checked against a frame-level reference model.
module tb_uart_rx_cfg;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rstN;
  logic       s_tick = 1'b0;
  logic [3:0] rxv;
  logic [3:0] done, pe_o, fe_o, busy_o;
  logic [7:0] dq0, dq1;
  logic [8:0] dq2;
  logic [6:0] dq3;
  logic [8:0] dq [4];
  int         tcnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    int         ch;
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } ev_t;

  ev_t evq[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tcnt   <= (tcnt == 2) ? 0 : tcnt + 1;
    s_tick <= (tcnt == 2);
  end

  uart_rx_cfg u0 (.clk(clk), .rstN(rstN), .rx(rxv[0]), .s_tick(s_tick), .dout(dq0),
                  .rx_done(done[0]), .parity_err(pe_o[0]), .frame_err(fe_o[0]), .busy(busy_o[0]));
  uart_rx_cfg #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (.clk(clk), .rstN(rstN), .rx(rxv[1]),
                  .s_tick(s_tick), .dout(dq1), .rx_done(done[1]), .parity_err(pe_o[1]),
                  .frame_err(fe_o[1]), .busy(busy_o[1]));
  uart_rx_cfg #(.DATA_BITS(9), .STOP_BITS(2)) u2 (.clk(clk), .rstN(rstN), .rx(rxv[2]),
                  .s_tick(s_tick), .dout(dq2), .rx_done(done[2]), .parity_err(pe_o[2]),
                  .frame_err(fe_o[2]), .busy(busy_o[2]));
  uart_rx_cfg #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1)) u3 (.clk(clk), .rstN(rstN),
                  .rx(rxv[3]), .s_tick(s_tick), .dout(dq3), .rx_done(done[3]),
                  .parity_err(pe_o[3]), .frame_err(fe_o[3]), .busy(busy_o[3]));

  assign dq[0] = {1'b0, dq0};
  assign dq[1] = {1'b0, dq1};
  assign dq[2] = dq2;
  assign dq[3] = {2'b00, dq3};

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (done[i] === 1'b1) evq.push_back('{i, dq[i], pe_o[i], fe_o[i]});
  end

  function automatic int nb_of(input int ch);
    case (ch)
      2:       return 9;
      3:       return 7;
      default: return 8;
    endcase
  endfunction

  function automatic int par_of(input int ch);
    return (ch == 1 || ch == 3) ? 1 : 0;
  endfunction

  function automatic int odd_of(input int ch);
    return (ch == 3) ? 1 : 0;
  endfunction

  function automatic int ns_of(input int ch);
    return (ch == 2) ? 2 : 1;
  endfunction

  // What a receiver should report for one frame as sent on the wire
  function automatic ev_t model(input int ch, input logic [8:0] data, input logic pbit,
                                input logic [1:0] stops);
    ev_t e;
    int  ones;
    logic want;
    ones = 0;
    e.ch = ch;
    e.d  = '0;
    for (int i = 0; i < nb_of(ch); i++) begin
      e.d[i] = data[i];
      if (data[i]) ones++;
    end
    want = (odd_of(ch) != 0) ? (ones % 2 == 0) : (ones % 2 == 1);
    e.pe = (par_of(ch) != 0) ? (pbit != want) : 1'b0;
    e.fe = (stops[0] == 1'b0) || (ns_of(ch) == 2 && stops[1] == 1'b0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int k);
    int c;
    c = 0;
    while (c < k) begin
      @(negedge clk);
      if (s_tick) c++;
    end
  endtask

  task automatic drive_bits(input int ch, input logic [15:0] bits, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      rxv[ch] = bits[i];
      wait_ticks(OS);
    end
  endtask

  task automatic send_frame(input int ch, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops);
    logic [15:0] b;
    int          pos;
    b   = '1;
    pos = 0;
    b[pos] = 1'b0; pos++;
    for (int i = 0; i < nb_of(ch); i++) begin
      b[pos] = data[i]; pos++;
    end
    if (par_of(ch) != 0) begin
      b[pos] = pbit; pos++;
    end
    for (int i = 0; i < ns_of(ch); i++) begin
      b[pos] = stops[i]; pos++;
    end
    drive_bits(ch, b, pos);
  endtask

  task automatic expect_frame(input string tag, input ev_t exp);
    ev_t got;
    int  w;
    w = 0;
    while (evq.size() == 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_done"}, 32'(evq.size() != 0), 32'd1);
    if (evq.size() != 0) begin
      got = evq.pop_front();
      chk({tag, "_ch"}, got.ch, exp.ch);
      chk({tag, "_dout"}, 32'(got.d), 32'(exp.d));
      chk({tag, "_perr"}, 32'(got.pe), 32'(exp.pe));
      chk({tag, "_ferr"}, 32'(got.fe), 32'(exp.fe));
    end
  endtask

  initial begin
    int         ch;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stops;

    rxv  = 4'hF;
    rstN = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_dout", 32'(dq0), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_perr", 32'(pe_o[0]), 32'd0);
    chk("rst_ferr", 32'(fe_o[0]), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rstN = 1'b1;
    wait_ticks(OS);

    // plain 8N1 frame
    send_frame(0, 9'h0A5, 1'b0, 2'b11);
    rxv[0] = 1'b1;
    wait_ticks(OS);
    expect_frame("a5", model(0, 9'h0A5, 1'b0, 2'b11));
    chk("a5_busy", 32'(busy_o[0]), 32'd0);

    // even parity, good then bad parity bit
    send_frame(1, 9'h007, 1'b1, 2'b11);
    wait_ticks(OS);
    expect_frame("par_ok", '{1, 9'h007, 1'b0, 1'b0});
    send_frame(1, 9'h007, 1'b0, 2'b11);
    wait_ticks(OS);
    expect_frame("par_bad", '{1, 9'h007, 1'b1, 1'b0});

    // stop bit low: frame error, then held in break while line stays low
    send_frame(0, 9'h03C, 1'b0, 2'b00);
    expect_frame("brk", '{0, 9'h03C, 1'b0, 1'b1});
    wait_ticks(2 * OS);
    chk("brk_busy", 32'(busy_o[0]), 32'd1);
    chk("brk_noev", 32'(evq.size()), 32'd0);
    rxv[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("brk_idle", 32'(busy_o[0]), 32'd0);
    wait_ticks(OS);

    // short low glitch on the start bit
    rxv[0] = 1'b0;
    wait_ticks(4);
    chk("gl_busy_hi", 32'(busy_o[0]), 32'd1);
    rxv[0] = 1'b1;
    wait_ticks(OS);
    chk("gl_noev", 32'(evq.size()), 32'd0);
    chk("gl_busy_lo", 32'(busy_o[0]), 32'd0);
    chk("gl_dout", 32'(dq0), 32'h3C);
    chk("gl_ferr_hold", 32'(fe_o[0]), 32'd1);

    // 9 data bits, 2 stop bits, back-to-back frames then a low second stop bit
    send_frame(2, 9'h1F3, 1'b0, 2'b11);
    send_frame(2, 9'h00C, 1'b0, 2'b11);
    wait_ticks(OS);
    expect_frame("b2b_1", '{2, 9'h1F3, 1'b0, 1'b0});
    expect_frame("b2b_2", '{2, 9'h00C, 1'b0, 1'b0});
    send_frame(2, 9'h0AA, 1'b0, 2'b01);
    rxv[2] = 1'b1;
    wait_ticks(OS);
    expect_frame("stop2_low", '{2, 9'h0AA, 1'b0, 1'b1});
    chk("b2b_noextra", 32'(evq.size()), 32'd0);

    // reset in the middle of the data bits
    drive_bits(0, 16'h0004, 4);
    wait_ticks(OS / 2);
    rstN = 1'b0;
    #1;
    chk("mid_rst_dout", 32'(dq0), 32'd0);
    chk("mid_rst_ferr", 32'(fe_o[0]), 32'd0);
    chk("mid_rst_done", 32'(done[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy_o[0]), 32'd0);
    rxv[0] = 1'b1;
    repeat (4) @(negedge clk);
    rstN = 1'b1;
    wait_ticks(2 * OS);
    chk("mid_rst_noev", 32'(evq.size()), 32'd0);
    send_frame(0, 9'h055, 1'b0, 2'b11);
    wait_ticks(OS);
    expect_frame("post_rst", '{0, 9'h055, 1'b0, 1'b0});

    // random frames across all configurations
    for (int k = 0; k < 16; k++) begin
      ch       = $urandom_range(0, 3);
      data     = 9'($urandom);
      pbit     = 1'($urandom_range(0, 1));
      stops[0] = ($urandom_range(0, 3) != 0);
      stops[1] = ($urandom_range(0, 3) != 0);
      send_frame(ch, data, pbit, stops);
      rxv[ch] = 1'b1;
      wait_ticks(OS);
      expect_frame("rnd", model(ch, data, pbit, stops));
    end
    wait_ticks(OS);
    chk("final_noev", 32'(evq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
